time_entry_counter: RTL and testbench
=====================================

TIME_ENTRY_COUNTER -- requirements
Module: time_entry_counter

Interface
REQ-001 Parameter SEC_TENS_MAX, default 5, is the sec_tens value loaded on a borrow from mins.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 keypad  in  10  key levels; bit i high = digit key i held.
REQ-005 start  in  1  level; start or resume countdown.
REQ-006 stop  in  1  level; pause countdown.
REQ-007 clear  in  1  level; zero all digits and return to entry.
REQ-008 tick  in  1  one-cycle enable pulse at 1 Hz from an external divider.
REQ-009 sec_ones  out  4  BCD seconds-units digit, registered.
REQ-010 sec_tens  out  4  BCD seconds-tens digit, registered.
REQ-011 mins  out  4  BCD minutes digit, registered.
REQ-012 running  out  1  high only in RUN.
REQ-013 done  out  1  one-cycle pulse when countdown reaches zero.

Function
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE and DONE.
REQ-015 A key press SHALL be accepted only on the cycle keypad goes from all-zero in the previous cycle to exactly one bit set; multi-bit or held patterns are ignored.
REQ-016 In IDLE, an accepted press of digit d SHALL shift the display left on the next edge: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=d; the old mins is discarded.
REQ-017 Key presses in RUN, PAUSE and DONE SHALL be ignored, but edge history SHALL still be tracked.
REQ-018 IDLE->RUN on start when the digits are nonzero; start with all digits zero SHALL leave the FSM in IDLE.
REQ-019 In RUN, each tick SHALL decrement the time by one second in BCD.
REQ-020 sec_ones 0 SHALL borrow: sec_ones<=9 and sec_tens decrements.
REQ-021 sec_ones and sec_tens both 0 SHALL borrow from mins: sec_tens<=SEC_TENS_MAX and sec_ones<=9.
REQ-022 A decrement yielding 0:00 SHALL move the FSM RUN->DONE on that edge.
REQ-023 DONE SHALL last exactly one cycle with done=1, then go to IDLE with digits at zero.
REQ-024 RUN->PAUSE on stop; PAUSE->RUN on start; tick is ignored in PAUSE.
REQ-025 clear in any state SHALL zero all digits and enter IDLE on the next edge.
REQ-026 Same-cycle priority SHALL be clear > stop > start > tick > key; stop with tick in RUN gives PAUSE with no decrement.
REQ-027 Entered sec_tens values above 5 SHALL be kept and counted down arithmetically, with no normalisation.

Reset
REQ-028 While reset is high, all digits SHALL be 0, state SHALL be IDLE, running=0, done=0 and the key-history register SHALL be 0.
REQ-029 Reset asserted mid-countdown SHALL abort immediately, with no done pulse.

Structure
REQ-030 A shared package SHALL hold the state enum, the 4-bit BCD digit type and the BCD constants 0, 9 and the SEC_TENS_MAX default.
REQ-031 The one-hot-to-BCD conversion SHALL be a combinational sub-module keypad_encoder (10-bit in, 4-bit digit plus valid out), with valid set only when exactly one bit is high.

Verification
REQ-032 Press 1, 3, 0 in IDLE -> mins=1, sec_tens=3, sec_ones=0, each update one edge after the press edge.
REQ-033 Load 1:00, start, 1 tick -> 0:59; 59 more ticks -> 0:00 with DONE, done high for 1 cycle, then IDLE.
REQ-034 Hold keypad=0000000100 for 5 cycles -> single shift only; keypad=0000000110 -> no change.
REQ-035 In RUN at 0:45, assert stop and tick together -> PAUSE at 0:45; then start plus 1 tick -> 0:44.
REQ-036 Start with 0:00 -> FSM stays IDLE, running=0; clear during RUN at 2:10 -> 0:00 in IDLE next edge, done=0.
REQ-037 Assert reset mid-RUN at 0:05 -> all outputs 0 asynchronously, no done pulse after release.

Source files
------------

// File: rtl/time_entry_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_entry_counter_pkg
//  Description : Shared types and constants for the keypad-entry countdown
//                timer: controller state enum, BCD digit type, BCD constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package time_entry_counter_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One BCD digit
  typedef logic [3:0] bcd_t;

  localparam bcd_t C_BCD_ZERO     = 4'd0;
  localparam bcd_t C_BCD_NINE     = 4'd9;
  localparam bcd_t C_SEC_TENS_MAX = 4'd5;

endpackage
`default_nettype wire

// File: rtl/keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_encoder
//  Description : Combinational one-hot to BCD encoder for a 10-key pad.
//                o_valid is high only when exactly one key bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_encoder
  import time_entry_counter_pkg::*;
(
  input  logic [9:0] i_keys,
  output bcd_t       o_digit,
  output logic       o_valid
);

  logic [3:0] w_count;

  // Count set bits and remember the index of the (last) set bit
  always_comb begin
    w_count = 4'd0;
    o_digit = C_BCD_ZERO;
    for (int i = 0; i < 10; i++) begin
      if (i_keys[i]) begin
        w_count = w_count + 4'd1;
        o_digit = 4'(i);
      end
    end
    o_valid = (w_count == 4'd1);
  end

endmodule
`default_nettype wire

// File: rtl/time_entry_counter.sv
`default_nettype none
// ============================================================================
//  Module      : time_entry_counter
//  Description : Keypad-entered M:SS countdown timer. Digits shift in from
//                the right while idle; a 1 Hz tick counts down in BCD while
//                running, with a one-cycle done pulse on reaching 0:00.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_entry_counter
  import time_entry_counter_pkg::*;
#(
  parameter bcd_t SEC_TENS_MAX = C_SEC_TENS_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keypad,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       tick,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       running,
  output logic       done
);

  state_e     r_state;
  bcd_t       r_sec_ones;
  bcd_t       r_sec_tens;
  bcd_t       r_mins;
  logic [9:0] r_key_prev;

  state_e     w_state_nxt;
  bcd_t       w_sec_ones_nxt;
  bcd_t       w_sec_tens_nxt;
  bcd_t       w_mins_nxt;
  bcd_t       w_key_digit;
  logic       w_key_valid;
  logic       w_key_accept;
  logic       w_nonzero;

  keypad_encoder u_keypad_encoder (
    .i_keys  (keypad),
    .o_digit (w_key_digit),
    .o_valid (w_key_valid)
  );

  // A press counts only on the rising edge from an all-released keypad
  assign w_key_accept = (r_key_prev == 10'd0) && w_key_valid;
  assign w_nonzero    = (r_mins != C_BCD_ZERO) || (r_sec_tens != C_BCD_ZERO) ||
                        (r_sec_ones != C_BCD_ZERO);

  // State, digit and key-history registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_sec_ones <= C_BCD_ZERO;
      r_sec_tens <= C_BCD_ZERO;
      r_mins     <= C_BCD_ZERO;
      r_key_prev <= 10'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_sec_ones <= w_sec_ones_nxt;
      r_sec_tens <= w_sec_tens_nxt;
      r_mins     <= w_mins_nxt;
      r_key_prev <= keypad;
    end
  end

  // Next state and next digits; clear > stop > start > tick > key, where an
  // input only takes part in a state in which it has an effect
  always_comb begin
    w_state_nxt    = r_state;
    w_sec_ones_nxt = r_sec_ones;
    w_sec_tens_nxt = r_sec_tens;
    w_mins_nxt     = r_mins;
    if (clear) begin
      w_state_nxt    = ST_IDLE;
      w_sec_ones_nxt = C_BCD_ZERO;
      w_sec_tens_nxt = C_BCD_ZERO;
      w_mins_nxt     = C_BCD_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && w_nonzero) begin
            w_state_nxt = ST_RUN;
          end else if (w_key_accept) begin
            w_mins_nxt     = r_sec_tens;
            w_sec_tens_nxt = r_sec_ones;
            w_sec_ones_nxt = w_key_digit;
          end
        end
        ST_RUN: begin
          if (stop) begin
            w_state_nxt = ST_PAUSE;
          end else if (tick) begin
            if (r_sec_ones != C_BCD_ZERO) begin
              w_sec_ones_nxt = r_sec_ones - 4'd1;
            end else if (r_sec_tens != C_BCD_ZERO) begin
              w_sec_ones_nxt = C_BCD_NINE;
              w_sec_tens_nxt = r_sec_tens - 4'd1;
            end else begin
              w_sec_ones_nxt = C_BCD_NINE;
              w_sec_tens_nxt = SEC_TENS_MAX;
              w_mins_nxt     = r_mins - 4'd1;
            end
            // The only decrement that lands on 0:00 starts from 0:01
            if ((r_mins == C_BCD_ZERO) && (r_sec_tens == C_BCD_ZERO) &&
                (r_sec_ones == 4'd1)) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          // A held stop keeps the timer paused even if start is also high
          if (!stop && start) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          w_state_nxt    = ST_IDLE;
          w_sec_ones_nxt = C_BCD_ZERO;
          w_sec_tens_nxt = C_BCD_ZERO;
          w_mins_nxt     = C_BCD_ZERO;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign sec_ones = r_sec_ones;
  assign sec_tens = r_sec_tens;
  assign mins     = r_mins;
  assign running  = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_time_entry_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_entry_counter
//  Description : Self-checking bench for time_entry_counter. A seconds-level
//                model (minutes plus a 0..99 seconds field) predicts outputs
//                every cycle; directed scenarios pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_entry_counter;

  localparam int C_TENS_MAX = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk;
  logic       reset;
  logic [9:0] keypad;
  logic       start, stop, clear, tick;
  logic [3:0] sec_ones, sec_tens, mins;
  logic       running, done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Model: minutes, seconds field (tens*10+ones), mode, previous keypad
  int         e_m, e_s, e_mode;
  logic [9:0] e_prev;

  time_entry_counter #(.SEC_TENS_MAX(4'd5)) dut (
    .clk      (clk),
    .reset    (reset),
    .keypad   (keypad),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .tick     (tick),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .mins     (mins),
    .running  (running),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the currently applied inputs
  task automatic model_step();
    int d;
    bit key_ok;
    key_ok = (e_prev == 10'd0) && ($countones(keypad) == 1);
    d = 0;
    for (int i = 0; i < 10; i++) if (keypad[i]) d = i;
    if (clear) begin
      e_m = 0; e_s = 0; e_mode = M_IDLE;
    end else begin
      case (e_mode)
        M_IDLE: begin
          if (start && (e_m != 0 || e_s != 0)) e_mode = M_RUN;
          else if (key_ok) begin
            e_m = e_s / 10;
            e_s = (e_s % 10) * 10 + d;
          end
        end
        M_RUN: begin
          if (stop) e_mode = M_PAUSE;
          else if (tick) begin
            if (e_s > 0) e_s = e_s - 1;
            else begin
              e_m = e_m - 1;
              e_s = C_TENS_MAX * 10 + 9;
            end
            if (e_m == 0 && e_s == 0) e_mode = M_DONE;
          end
        end
        M_PAUSE: if (!stop && start) e_mode = M_RUN;
        default: begin
          e_mode = M_IDLE; e_m = 0; e_s = 0;
        end
      endcase
    end
    e_prev = keypad;
  endtask

  // One clock: drive on the falling edge, update the model just after rising
  task automatic cycle(input logic [9:0] kp, input logic st, input logic sp,
                       input logic cl, input logic tk);
    @(negedge clk);
    keypad = kp; start = st; stop = sp; clear = cl; tick = tk;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(10'd0, 0, 0, 0, 0);
  endtask

  task automatic press(input int d);
    logic [9:0] k;
    k = 10'd1 << d;
    cycle(k, 0, 0, 0, 0);
    cycle(10'd0, 0, 0, 0, 0);
  endtask

  // Literal check of the displayed time against both DUT and model
  task automatic pin_time(input string name, input int m, input int s);
    chk({name, "_dut"}, mins * 100 + sec_tens * 10 + sec_ones, m * 100 + s);
    chk({name, "_model"}, e_m * 100 + e_s, m * 100 + s);
  endtask

  // Compare the DUT to the model on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sec_ones", sec_ones, e_s % 10);
      chk("sec_tens", sec_tens, e_s / 10);
      chk("mins", mins, e_m);
      chk("running", running, (e_mode == M_RUN) ? 1 : 0);
      chk("done", done, (e_mode == M_DONE) ? 1 : 0);
    end
  end

  initial begin
    logic [9:0] kp;
    reset = 1'b1; keypad = 10'd0; start = 0; stop = 0; clear = 0; tick = 0;
    e_m = 0; e_s = 0; e_mode = M_IDLE; e_prev = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_time", mins * 100 + sec_tens * 10 + sec_ones, 0);
    chk("reset_running", running, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    cmp_en = 1;

    // Digit entry 1,3,0
    press(1);
    pin_time("after_1", 0, 1);
    press(3);
    press(0);
    pin_time("press_130", 1, 30);

    // 1:00 countdown to done
    cycle(10'd0, 0, 0, 1, 0);
    press(1); press(0); press(0);
    cycle(10'd0, 1, 0, 0, 0);
    chk("run_started", running, 1);
    cycle(10'd0, 0, 0, 0, 1);
    pin_time("first_tick", 0, 59);
    for (int i = 0; i < 59; i++) begin
      cycle(10'd0, 0, 0, 0, 1);
      if (i != 58) idle(1);
    end
    chk("done_pulse", done, 1);
    pin_time("at_zero", 0, 0);
    idle(1);
    chk("done_after", done, 0);
    chk("idle_after_done", running, 0);

    // Held key gives one shift; two-key pattern ignored
    for (int i = 0; i < 5; i++) cycle(10'h004, 0, 0, 0, 0);
    idle(1);
    pin_time("held_key", 0, 2);
    for (int i = 0; i < 3; i++) cycle(10'h006, 0, 0, 0, 0);
    idle(1);
    pin_time("multi_key", 0, 2);

    // Stop with tick at 0:45, then resume and tick
    cycle(10'd0, 0, 0, 1, 0);
    press(4); press(5);
    cycle(10'd0, 1, 0, 0, 0);
    cycle(10'd0, 0, 1, 0, 1);
    pin_time("pause_45", 0, 45);
    chk("paused", running, 0);
    cycle(10'd0, 0, 0, 0, 1);
    pin_time("pause_tick_ignored", 0, 45);
    cycle(10'd0, 1, 0, 0, 0);
    cycle(10'd0, 0, 0, 0, 1);
    pin_time("resume_44", 0, 44);

    // Start at zero stays idle; clear during run
    cycle(10'd0, 0, 0, 1, 0);
    cycle(10'd0, 1, 0, 0, 0);
    chk("start_zero_running", running, 0);
    press(2); press(1); press(0);
    cycle(10'd0, 1, 0, 0, 0);
    chk("run_210", running, 1);
    cycle(10'd0, 0, 0, 1, 0);
    pin_time("clear_run", 0, 0);
    chk("clear_running", running, 0);
    chk("clear_done", done, 0);

    // Tens above five counts down arithmetically: 0:71 -> 0:70 -> 0:69
    press(7); press(1);
    cycle(10'd0, 1, 0, 0, 0);
    cycle(10'd0, 0, 0, 0, 1);
    cycle(10'd0, 0, 0, 0, 1);
    pin_time("tens_over_max", 0, 69);

    // Async reset mid-run at 0:05
    cycle(10'd0, 0, 0, 1, 0);
    press(5);
    cycle(10'd0, 1, 0, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_time", mins * 100 + sec_tens * 10 + sec_ones, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_done", done, 0);
    e_m = 0; e_s = 0; e_mode = M_IDLE; e_prev = 10'd0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    chk("no_done_after_reset", done, 0);

    // Randomised traffic against the model
    kp = 10'd0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 7) kp = 10'd0;
      else if (r < 12) kp = 10'd1 << $urandom_range(0, 9);
      else if (r < 14) kp = 10'($urandom);
      cycle(kp, ($urandom_range(0, 11) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0));
    end

    idle(2);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
